// File: rtl/sparc_ifu_mrqbuf.sv
// Per-thread I-cache miss request buffer around the IFU thread arbiter (4 threads). Optional MRQ_BYPASS_EN: issue straight from fcl when all threads idle.
// Latency: load->val 2 cycles through PEND/arbiter (1 cycle with MRQ_BYPASS_EN bypass).
// Backpressure: LSU request held stable under val until ack; back-to-back issue on the ack cycle.
module sparc_ifu_mrqbuf #(
    parameter int AW = 40
) (
    input  logic          clk,
    input  logic          arst_l,
    input  logic          se,
    input  logic          si,
    output logic          so,
    input  logic [3:0]    fcl_mrq_load_t,
    input  logic [AW-1:0] fcl_mrq_paddr,
    input  logic          fcl_mrq_nc,
    input  logic [3:0]    ifu_mrq_flush_t,
    output logic [3:0]    mrq_req_vec,
    input  logic [3:0]    arb_mrq_grant_vec,
    output logic          mrq_advance,
    output logic          mrq_lsu_req_val,
    output logic [AW-1:0] mrq_lsu_pa,
    output logic [1:0]    mrq_lsu_tid,
    output logic          mrq_lsu_nc,
    input  logic          lsu_mrq_ack,
    input  logic [3:0]    lsu_mrq_fill_t,
    output logic          mrq_fill_stale,
    output logic [3:0]    mrq_pending_t
);

    typedef enum logic {
        ISS_IDLE = 1'b0,
        ISS_REQ  = 1'b1
    } iss_state_e;

    iss_state_e    iss_q, iss_d;
    logic [3:0]    pend_q, pend_d;
    logic [3:0]    out_q, out_d;
    logic [3:0]    stale_q, stale_d;
    logic [3:0]    cap_vec;
    logic [AW-1:0] pa_q [4];
    logic [3:0]    nc_q;

    logic [3:0]    sel_vec;
    logic [3:0]    take_vec;
    logic          issue_win;
    logic          sel_ok;
    logic          byp_ok;
    logic          issue;
    logic [1:0]    iss_tid;

    function automatic logic [1:0] enc4(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Scan is not modelled; so simply mirrors si while scanning.
    assign so = se & si;

    assign mrq_req_vec    = pend_q;
    assign mrq_pending_t  = pend_q | out_q;
    assign mrq_fill_stale = |(lsu_mrq_fill_t & stale_q);

    // A grant only selects when it lands on a PEND thread that is not being flushed.
    assign sel_vec   = arb_mrq_grant_vec & pend_q & ~ifu_mrq_flush_t;
    assign issue_win = (iss_q == ISS_IDLE) || lsu_mrq_ack;
    assign sel_ok    = issue_win && (|sel_vec);

`ifdef MRQ_BYPASS_EN
    assign byp_ok = issue_win && !(|(pend_q | out_q)) && (|fcl_mrq_load_t)
                    && !(|(fcl_mrq_load_t & ifu_mrq_flush_t));
`else
    assign byp_ok = 1'b0;
`endif

    assign issue       = sel_ok || byp_ok;
    assign take_vec    = byp_ok ? fcl_mrq_load_t : sel_vec;
    assign iss_tid     = enc4(take_vec);
    assign mrq_advance = issue;

    always_comb begin
        iss_d = iss_q;
        if (issue) begin
            iss_d = ISS_REQ;
        end else if (lsu_mrq_ack) begin
            iss_d = ISS_IDLE;
        end
    end

    // Per-thread priority: flush > fill > load > selection.
    always_comb begin
        pend_d  = pend_q;
        out_d   = out_q;
        stale_d = stale_q;
        cap_vec = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (ifu_mrq_flush_t[i]) begin
                if (out_q[i]) stale_d[i] = 1'b1;
                else          pend_d[i]  = 1'b0;
            end else if (lsu_mrq_fill_t[i] && out_q[i]) begin
                out_d[i]   = 1'b0;
                stale_d[i] = 1'b0;
                if (fcl_mrq_load_t[i]) begin
                    pend_d[i]  = 1'b1;
                    cap_vec[i] = 1'b1;
                end
            end else if (fcl_mrq_load_t[i] && !pend_q[i] && !out_q[i]) begin
                cap_vec[i] = 1'b1;
                if (byp_ok) out_d[i]  = 1'b1;
                else        pend_d[i] = 1'b1;
            end else if (sel_vec[i] && sel_ok) begin
                pend_d[i] = 1'b0;
                out_d[i]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            iss_q   <= ISS_IDLE;
            pend_q  <= 4'b0000;
            out_q   <= 4'b0000;
            stale_q <= 4'b0000;
            nc_q    <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                pa_q[i] <= '0;
            end
        end else begin
            iss_q   <= iss_d;
            pend_q  <= pend_d;
            out_q   <= out_d;
            stale_q <= stale_d;
            for (int i = 0; i < 4; i++) begin
                if (cap_vec[i]) begin
                    pa_q[i] <= fcl_mrq_paddr;
                    nc_q[i] <= fcl_mrq_nc;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            mrq_lsu_req_val <= 1'b0;
            mrq_lsu_pa      <= '0;
            mrq_lsu_tid     <= 2'd0;
            mrq_lsu_nc      <= 1'b0;
        end else if (issue) begin
            mrq_lsu_req_val <= 1'b1;
            mrq_lsu_pa      <= byp_ok ? fcl_mrq_paddr : pa_q[iss_tid];
            mrq_lsu_nc      <= byp_ok ? fcl_mrq_nc : nc_q[iss_tid];
            mrq_lsu_tid     <= iss_tid;
        end else if (lsu_mrq_ack) begin
            mrq_lsu_req_val <= 1'b0;
        end
    end

    a_load_onehot: assert property (@(posedge clk) disable iff (!arst_l)
        $onehot0(fcl_mrq_load_t));
    a_load_busy: assert property (@(posedge clk) disable iff (!arst_l)
        !(|(fcl_mrq_load_t & ~ifu_mrq_flush_t & (pend_q | (out_q & ~lsu_mrq_fill_t)))));
    a_fill_idle: assert property (@(posedge clk) disable iff (!arst_l)
        !(|(lsu_mrq_fill_t & ~out_q)));

endmodule

// File: tb/tb_sparc_ifu_mrqbuf.sv
// Randomized + directed bench for sparc_ifu_mrqbuf against a per-thread state model with a round-robin arbiter stand-in.
module tb_sparc_ifu_mrqbuf;
    localparam int AW = 40;

    logic          clk = 1'b0;
    logic          arst_l;
    logic          se, si, so;
    logic [3:0]    fcl_mrq_load_t;
    logic [AW-1:0] fcl_mrq_paddr;
    logic          fcl_mrq_nc;
    logic [3:0]    ifu_mrq_flush_t;
    logic [3:0]    mrq_req_vec;
    logic [3:0]    arb_mrq_grant_vec;
    logic          mrq_advance;
    logic          mrq_lsu_req_val;
    logic [AW-1:0] mrq_lsu_pa;
    logic [1:0]    mrq_lsu_tid;
    logic          mrq_lsu_nc;
    logic          lsu_mrq_ack;
    logic [3:0]    lsu_mrq_fill_t;
    logic          mrq_fill_stale;
    logic [3:0]    mrq_pending_t;

    sparc_ifu_mrqbuf #(.AW(AW)) dut (
        .clk(clk), .arst_l(arst_l), .se(se), .si(si), .so(so),
        .fcl_mrq_load_t(fcl_mrq_load_t), .fcl_mrq_paddr(fcl_mrq_paddr),
        .fcl_mrq_nc(fcl_mrq_nc), .ifu_mrq_flush_t(ifu_mrq_flush_t),
        .mrq_req_vec(mrq_req_vec), .arb_mrq_grant_vec(arb_mrq_grant_vec),
        .mrq_advance(mrq_advance), .mrq_lsu_req_val(mrq_lsu_req_val),
        .mrq_lsu_pa(mrq_lsu_pa), .mrq_lsu_tid(mrq_lsu_tid), .mrq_lsu_nc(mrq_lsu_nc),
        .lsu_mrq_ack(lsu_mrq_ack), .lsu_mrq_fill_t(lsu_mrq_fill_t),
        .mrq_fill_stale(mrq_fill_stale), .mrq_pending_t(mrq_pending_t)
    );

    always #5 clk = ~clk;

    typedef enum int { M_IDLE, M_PEND, M_OUT } mstate_t;

    mstate_t       ms [4];
    bit            mst [4];
    logic [AW-1:0] mpa [4];
    bit            mnc [4];
    bit            issued [4];
    bit            m_val;
    logic [AW-1:0] m_lpa;
    int            m_tid;
    bit            m_lnc;
    int            ptr;
    int            n_chk = 0;
    int            n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic reset_model();
        for (int i = 0; i < 4; i++) begin
            ms[i] = M_IDLE; mst[i] = 1'b0; mpa[i] = '0; mnc[i] = 1'b0; issued[i] = 1'b0;
        end
        m_val = 1'b0; m_lpa = '0; m_tid = 0; m_lnc = 1'b0; ptr = 0;
    endtask

    function automatic logic [3:0] vec_of(input mstate_t s);
        logic [3:0] v;
        v = 4'b0000;
        for (int i = 0; i < 4; i++) if (ms[i] == s) v[i] = 1'b1;
        return v;
    endfunction

    // Round robin starting after the last advanced thread; parks on ptr when nothing requests.
    function automatic logic [3:0] rr_grant(input logic [3:0] req);
        logic [3:0] g;
        g = 4'b0001 << ptr;
        for (int k = 4; k >= 1; k--) begin
            if (req[(ptr + k) % 4]) g = 4'b0001 << ((ptr + k) % 4);
        end
        return g;
    endfunction

    task automatic step(input logic [3:0] ld, input logic [AW-1:0] pa, input logic nc,
                        input logic [3:0] fl, input logic [3:0] fi, input logic ak,
                        input logic force_g, input logic [3:0] fg);
        logic [3:0] pendv, outv, stv, sel;
        bit ok;
        int t;
        @(negedge clk);
        pendv = vec_of(M_PEND);
        outv  = vec_of(M_OUT);
        stv   = 4'b0000;
        for (int i = 0; i < 4; i++) stv[i] = mst[i];
        chk("req_vec", 64'(mrq_req_vec), 64'(pendv));
        chk("pending_t", 64'(mrq_pending_t), 64'(pendv | outv));
        chk("req_val", 64'(mrq_lsu_req_val), 64'(m_val));
        chk("lsu_pa", 64'(mrq_lsu_pa), 64'(m_lpa));
        chk("lsu_tid", 64'(mrq_lsu_tid), 64'(m_tid));
        chk("lsu_nc", 64'(mrq_lsu_nc), 64'(m_lnc));
        fcl_mrq_load_t    = ld;
        fcl_mrq_paddr     = pa;
        fcl_mrq_nc        = nc;
        ifu_mrq_flush_t   = fl;
        lsu_mrq_fill_t    = fi;
        lsu_mrq_ack       = ak;
        arb_mrq_grant_vec = force_g ? fg : rr_grant(pendv);
        #1;
        sel = arb_mrq_grant_vec & pendv & ~fl;
        ok  = (!m_val || ak) && (sel != 4'b0000);
        t   = 0;
        for (int i = 3; i >= 0; i--) if (sel[i]) t = i;
        chk("advance", 64'(mrq_advance), 64'(ok));
        chk("fill_stale", 64'(mrq_fill_stale), 64'(|(fi & stv)));
        if (m_val && ak) issued[m_tid] = 1'b1;
        if (ok) begin
            m_val = 1'b1; m_lpa = mpa[t]; m_lnc = mnc[t]; m_tid = t; ptr = t;
        end else if (ak) begin
            m_val = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            if (fl[i]) begin
                if (ms[i] == M_OUT) mst[i] = 1'b1;
                else ms[i] = M_IDLE;
            end else if (fi[i] && ms[i] == M_OUT) begin
                ms[i] = ld[i] ? M_PEND : M_IDLE;
                mst[i] = 1'b0;
                issued[i] = 1'b0;
                if (ld[i]) begin mpa[i] = pa; mnc[i] = nc; end
            end else if (ld[i] && ms[i] == M_IDLE) begin
                ms[i] = M_PEND; mpa[i] = pa; mnc[i] = nc;
            end else if (ok && t == i) begin
                ms[i] = M_OUT;
            end
        end
    endtask

    task automatic idle(input logic ak);
        step(4'b0000, '0, 1'b0, 4'b0000, 4'b0000, ak, 1'b0, 4'b0000);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_val"}, 64'(mrq_lsu_req_val), 64'd0);
        chk({tag, "_pa"}, 64'(mrq_lsu_pa), 64'd0);
        chk({tag, "_tid"}, 64'(mrq_lsu_tid), 64'd0);
        chk({tag, "_nc"}, 64'(mrq_lsu_nc), 64'd0);
        chk({tag, "_reqvec"}, 64'(mrq_req_vec), 64'd0);
        chk({tag, "_adv"}, 64'(mrq_advance), 64'd0);
        chk({tag, "_pend"}, 64'(mrq_pending_t), 64'd0);
        chk({tag, "_stale"}, 64'(mrq_fill_stale), 64'd0);
    endtask

    initial begin
        logic [63:0]   r;
        logic [AW-1:0] rpa;
        logic [3:0]    ld, fl, fi;
        logic          ak;
        int            t;
        arst_l = 1'b0; se = 1'b0; si = 1'b0;
        fcl_mrq_load_t = 4'b0; fcl_mrq_paddr = '0; fcl_mrq_nc = 1'b0;
        ifu_mrq_flush_t = 4'b0; arb_mrq_grant_vec = 4'b0; lsu_mrq_ack = 1'b0;
        lsu_mrq_fill_t = 4'b0;
        reset_model();
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        arst_l = 1'b1;

        // Single miss on t2, ack after three val cycles, then fill.
        step(4'b0100, 40'h00_1234_5640, 1'b0, 4'b0, 4'b0, 1'b0, 1'b0, 4'b0);
        idle(1'b0);
        idle(1'b0);
        chk("t2_tid", 64'(mrq_lsu_tid), 64'd2);
        chk("t2_pa", 64'(mrq_lsu_pa), 64'h00_1234_5640);
        idle(1'b0);
        idle(1'b1);
        step(4'b0, '0, 1'b0, 4'b0, 4'b0100, 1'b0, 1'b0, 4'b0);
        idle(1'b0);
        chk("t2_done", 64'(mrq_pending_t), 64'd0);

        // Back-to-back: t0, t1, t3 with ack held.
        step(4'b0001, 40'h11_0000_0040, 1'b1, 4'b0, 4'b0, 1'b1, 1'b0, 4'b0);
        step(4'b0010, 40'h22_0000_0080, 1'b0, 4'b0, 4'b0, 1'b1, 1'b0, 4'b0);
        step(4'b1000, 40'h33_0000_00c0, 1'b1, 4'b0, 4'b0, 1'b1, 1'b0, 4'b0);
        chk("b2b_tid0", 64'(mrq_lsu_tid), 64'd0);
        idle(1'b1);
        chk("b2b_tid1", 64'(mrq_lsu_tid), 64'd1);
        idle(1'b1);
        chk("b2b_tid3", 64'(mrq_lsu_tid), 64'd3);
        idle(1'b0);
        step(4'b0, '0, 1'b0, 4'b0, 4'b1011, 1'b0, 1'b0, 4'b0);
        idle(1'b0);

        // Flush before selection.
        step(4'b0010, 40'h44_0000_0100, 1'b0, 4'b0, 4'b0, 1'b0, 1'b0, 4'b0);
        step(4'b0, '0, 1'b0, 4'b0010, 4'b0, 1'b0, 1'b0, 4'b0);
        chk("flush_noadv", 64'(mrq_advance), 64'd0);
        idle(1'b0);
        idle(1'b0);

        // Flush while in request: val held, fill reported stale.
        step(4'b1000, 40'h55_0000_0140, 1'b1, 4'b0, 4'b0, 1'b0, 1'b0, 4'b0);
        idle(1'b0);
        step(4'b0, '0, 1'b0, 4'b1000, 4'b0, 1'b0, 1'b0, 4'b0);
        idle(1'b0);
        idle(1'b1);
        step(4'b0, '0, 1'b0, 4'b0, 4'b1000, 1'b0, 1'b0, 4'b0);
        chk("stale_fill", 64'(mrq_fill_stale), 64'd1);
        idle(1'b0);

        // Forced grant with nothing pending.
        step(4'b0, '0, 1'b0, 4'b0, 4'b0, 1'b0, 1'b1, 4'b0001);
        chk("force_noadv", 64'(mrq_advance), 64'd0);
        step(4'b0, '0, 1'b0, 4'b0, 4'b0, 1'b0, 1'b1, 4'b0001);
        idle(1'b0);

        // Reset mid-handshake with t0 outstanding.
        step(4'b0001, 40'h66_0000_0180, 1'b1, 4'b0, 4'b0, 1'b0, 1'b0, 4'b0);
        idle(1'b0);
        idle(1'b0);
        chk("pre_rst_val", 64'(mrq_lsu_req_val), 64'd1);
        @(negedge clk);
        #2 arst_l = 1'b0;
        #1 check_all_zero("midrst");
        reset_model();
        #1 arst_l = 1'b1;
        step(4'b0001, 40'h77_0000_01c0, 1'b0, 4'b0, 4'b0, 1'b0, 1'b0, 4'b0);
        idle(1'b0);
        idle(1'b1);
        chk("post_rst_pa", 64'(mrq_lsu_pa), 64'h77_0000_01c0);

        // Random legal traffic.
        for (int n = 0; n < 1500; n++) begin
            fi = 4'b0; fl = 4'b0; ld = 4'b0;
            for (int i = 0; i < 4; i++) begin
                if (ms[i] == M_OUT && issued[i] && $urandom_range(0, 3) == 0) fi[i] = 1'b1;
            end
            for (int i = 0; i < 4; i++) begin
                if (!fi[i] && $urandom_range(0, 11) == 0) fl[i] = 1'b1;
            end
            t = $urandom_range(0, 3);
            if ($urandom_range(0, 2) != 0 &&
                (ms[t] == M_IDLE || (ms[t] == M_OUT && fi[t]))) ld[t] = 1'b1;
            r   = {$urandom(), $urandom()};
            rpa = r[AW-1:0];
            ak  = m_val ? 1'($urandom_range(0, 1)) : 1'b0;
            step(ld, rpa, 1'($urandom_range(0, 1)), fl, fi, ak, 1'b0, 4'b0);
        end
        idle(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
